// File: rtl/npm_toggle_timer_primitive_if.sv
// PM command bus between a single-command controller (master) and a
// primitive executor such as the toggle timer (slave).
interface npm_toggle_timer_primitive_if;
  logic [7:0]  iPCommand;
  logic [2:0]  iPCommandOption;
  logic [15:0] iNumOfData;
  logic [7:0]  oPM_Ready;
  logic [7:0]  oPM_LastStep;

  modport master (
    output iPCommand,
    output iPCommandOption,
    output iNumOfData,
    input  oPM_Ready,
    input  oPM_LastStep
  );

  modport slave (
    input  iPCommand,
    input  iPCommandOption,
    input  iNumOfData,
    output oPM_Ready,
    output oPM_LastStep
  );
endinterface

// File: rtl/npm_toggle_timer_primitive.sv
// Toggle NAND timer primitive executor.
// Accepts a timer command on its own iPCommand bit while idle, counts down
// iNumOfData clock cycles (or prescaled ticks of PrescaleDiv cycles) and
// pulses LastStep for one cycle when the count reaches zero.
// Ready/LastStep are kept as flops loaded from the next-state decode, so
// they change only on clock edges and carry no combinational glitches,
// while keeping the exact cycle timing of a (state, count) decode.
module npm_toggle_timer_primitive #(
  parameter int unsigned PrescaleDiv = 100,
  parameter int unsigned PCommandBit = 0
) (
  input  logic                         iSystemClock,
  input  logic                         iReset,
  npm_toggle_timer_primitive_if.slave  pmBus
);

  // Prescaler must hold PrescaleDiv-1; keep at least one bit for PrescaleDiv=1.
  localparam int unsigned PrescW = (PrescaleDiv > 1) ? $clog2(PrescaleDiv) : 1;
  localparam logic [PrescW-1:0] PrescReload = PrescW'(PrescaleDiv - 1);
  // Only this bit of the one-hot command/status bytes belongs to this primitive.
  localparam logic [7:0] OwnMask = 8'h01 << PCommandBit;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } tState;

  tState             stateR;
  tState             stateNextS;
  logic [15:0]       countR;
  logic [15:0]       countNextS;
  logic [PrescW-1:0] prescR;
  logic [PrescW-1:0] prescNextS;
  logic              modeR;
  logic              modeNextS;
  logic              readyR;
  logic              readyNextS;
  logic              lastStepR;
  logic              lastStepNextS;
  logic              cmdOwnS;
  logic              prescModeSelS;

  // Count decrement that can never wrap below zero.
  function automatic logic [15:0] decSat(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'd0) begin
      result = 16'd0;
    end else begin
      result = value - 16'd1;
    end
    return result;
  endfunction

  // Masking the whole byte ignores every command bit except our own.
  assign cmdOwnS       = |(pmBus.iPCommand & OwnMask);
  assign prescModeSelS = (pmBus.iPCommandOption == 3'b001);

  // Next-state, counter and prescaler update plus next value of the status bits.
  always_comb begin
    stateNextS    = stateR;
    countNextS    = countR;
    prescNextS    = prescR;
    modeNextS     = modeR;
    readyNextS    = 1'b1;
    lastStepNextS = 1'b0;

    case (stateR)
      StIdle: begin
        if (cmdOwnS) begin
          stateNextS = StRun;
          countNextS = pmBus.iNumOfData;
          prescNextS = PrescReload;
          modeNextS  = prescModeSelS;
        end else begin
          stateNextS = StIdle;
        end
      end
      StRun: begin
        if (countR == 16'd0) begin
          // Completion cycle just ended; a command held here is not taken.
          stateNextS = StIdle;
        end else if (!modeR) begin
          countNextS = decSat(countR);
        end else if (prescR == {PrescW{1'b0}}) begin
          prescNextS = PrescReload;
          countNextS = decSat(countR);
        end else begin
          prescNextS = prescR - PrescW'(1);
        end
      end
      default: begin
        stateNextS = StIdle;
        countNextS = 16'd0;
        prescNextS = {PrescW{1'b0}};
        modeNextS  = 1'b0;
      end
    endcase

    readyNextS    = (stateNextS == StIdle);
    lastStepNextS = (stateNextS == StRun) && (countNextS == 16'd0);
  end

  // State, counter, prescaler, mode and status flops with asynchronous reset.
  always_ff @(posedge iSystemClock or negedge iReset) begin
    if (!iReset) begin
      stateR    <= StIdle;
      countR    <= 16'd0;
      prescR    <= {PrescW{1'b0}};
      modeR     <= 1'b0;
      readyR    <= 1'b1;
      lastStepR <= 1'b0;
    end else begin
      stateR    <= stateNextS;
      countR    <= countNextS;
      prescR    <= prescNextS;
      modeR     <= modeNextS;
      readyR    <= readyNextS;
      lastStepR <= lastStepNextS;
    end
  end

  assign pmBus.oPM_Ready    = readyR    ? OwnMask : 8'h00;
  assign pmBus.oPM_LastStep = lastStepR ? OwnMask : 8'h00;

endmodule

// File: tb/tb_npm_toggle_timer_primitive.sv
// Self-checking bench for npm_toggle_timer_primitive.
// Two instances: one on bit 0 with PrescaleDiv=4, one on bit 3 with PrescaleDiv=3.
// The reference model works from the delay rule: a command with count N
// completes in cycle L = N (cycle mode) or N*PrescaleDiv (option 3'b001);
// Ready is low in cycles 0..L, LastStep is high in cycle L only.
module tb_npm_toggle_timer_primitive;

  localparam int unsigned Div0 = 4;
  localparam int unsigned Div3 = 3;

  logic clk = 1'b0;
  logic rstN;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  npm_toggle_timer_primitive_if bus0 ();
  npm_toggle_timer_primitive_if bus3 ();

  npm_toggle_timer_primitive #(.PrescaleDiv(Div0), .PCommandBit(0)) dut0 (
    .iSystemClock (clk),
    .iReset       (rstN),
    .pmBus        (bus0)
  );

  npm_toggle_timer_primitive #(.PrescaleDiv(Div3), .PCommandBit(3)) dut3 (
    .iSystemClock (clk),
    .iReset       (rstN),
    .pmBus        (bus3)
  );

  function automatic logic [7:0] maskOf(input int which);
    return (which == 0) ? 8'h01 : 8'h08;
  endfunction

  function automatic int divOf(input int which);
    return (which == 0) ? int'(Div0) : int'(Div3);
  endfunction

  function automatic logic [7:0] rdyOf(input int which);
    return (which == 0) ? bus0.oPM_Ready : bus3.oPM_Ready;
  endfunction

  function automatic logic [7:0] lstOf(input int which);
    return (which == 0) ? bus0.oPM_LastStep : bus3.oPM_LastStep;
  endfunction

  task automatic drive(input int which, input logic [7:0] cmd, input logic [2:0] opt,
                       input logic [15:0] n);
    if (which == 0) begin
      bus0.iPCommand = cmd; bus0.iPCommandOption = opt; bus0.iNumOfData = n;
    end else begin
      bus3.iPCommand = cmd; bus3.iPCommandOption = opt; bus3.iNumOfData = n;
    end
  endtask

  // Called at a negedge inside an idle cycle. Issues one command, checks every
  // cycle up to the first Ready-high cycle (L+1) and returns at that negedge.
  // Inputs are scrambled during Run, including our own bit in the completion cycle.
  task automatic run_cmd(input int which, input logic [2:0] opt, input logic [15:0] n,
                         input string tag);
    logic [7:0] mask;
    logic [7:0] expR;
    logic [7:0] expL;
    logic [7:0] junk;
    int lastCyc;
    mask    = maskOf(which);
    lastCyc = (opt == 3'b001) ? int'(n) * divOf(which) : int'(n);
    testsRun++;
    if (rdyOf(which) !== mask) begin
      testsFailed++;
      $display("FAIL %s idle_ready got %h want %h", tag, rdyOf(which), mask);
    end
    drive(which, mask, opt, n);
    @(posedge clk);
    for (int k = 0; k <= lastCyc + 1; k++) begin
      @(negedge clk);
      expR = (k <= lastCyc) ? 8'h00 : mask;
      expL = (k == lastCyc) ? mask : 8'h00;
      testsRun++;
      if (rdyOf(which) !== expR) begin
        testsFailed++;
        $display("FAIL %s ready cycle %0d got %h want %h", tag, k, rdyOf(which), expR);
      end
      testsRun++;
      if (lstOf(which) !== expL) begin
        testsFailed++;
        $display("FAIL %s laststep cycle %0d got %h want %h", tag, k, lstOf(which), expL);
      end
      if (k <= lastCyc) begin
        junk = 8'($urandom) & ~mask;
        if (k == lastCyc && $urandom_range(0, 1) == 1) junk = junk | mask;
        drive(which, junk, 3'($urandom), 16'($urandom));
      end else begin
        drive(which, 8'h00, 3'($urandom), 16'($urandom));
      end
    end
  endtask

  task automatic test_reset();
    drive(0, 8'h00, 3'b000, 16'd0);
    drive(1, 8'h00, 3'b000, 16'd0);
    rstN = 1'b0;
    #12;
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #3;
    rstN = 1'b0;
    #1;
    for (int w = 0; w < 2; w++) begin
      testsRun++;
      if (rdyOf(w) !== maskOf(w)) begin
        testsFailed++;
        $display("FAIL reset_ready dut%0d got %h want %h", w, rdyOf(w), maskOf(w));
      end
      testsRun++;
      if (lstOf(w) !== 8'h00) begin
        testsFailed++;
        $display("FAIL reset_laststep dut%0d got %h want 00", w, lstOf(w));
      end
    end
    @(negedge clk);
    rstN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
        testsRun++;
        if (rdyOf(w) !== maskOf(w) || lstOf(w) !== 8'h00) begin
          testsFailed++;
          $display("FAIL post_reset dut%0d ready/laststep got %h/%h want %h/00",
                   w, rdyOf(w), lstOf(w), maskOf(w));
        end
      end
    end
  endtask

  task automatic test_cycle_long();
    run_cmd(0, 3'b000, 16'd11000, "cycle_long");
  endtask

  task automatic test_prescaled();
    run_cmd(0, 3'b001, 16'd3, "presc_n3");
    run_cmd(0, 3'b001, 16'd0, "presc_n0");
    run_cmd(0, 3'b000, 16'd0, "cycle_n0");
  endtask

  task automatic test_filtering();
    logic [7:0] expR;
    logic [7:0] expL;
    int rel;
    // Foreign command bits in Idle must never start the timer.
    drive(0, 8'hFE, 3'b000, 16'd3);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      testsRun++;
      if (bus0.oPM_Ready !== 8'h01 || bus0.oPM_LastStep !== 8'h00) begin
        testsFailed++;
        $display("FAIL filter_fe cycle %0d ready/laststep got %h/%h want 01/00",
                 k, bus0.oPM_Ready, bus0.oPM_LastStep);
      end
    end
    // Held command, reserved option 3'b101 = cycle mode, N=5. First run covers
    // cycles 0..5; cycle 6 is the first Ready-high cycle, so the held command
    // is taken at edge 7 and the second run occupies cycles 7..12.
    drive(0, 8'h01, 3'b101, 16'd5);
    @(posedge clk);
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      rel  = (k <= 6) ? k : k - 7;
      expR = (rel <= 5) ? 8'h00 : 8'h01;
      expL = (rel == 5) ? 8'h01 : 8'h00;
      testsRun++;
      if (bus0.oPM_Ready !== expR) begin
        testsFailed++;
        $display("FAIL hold_ready cycle %0d got %h want %h", k, bus0.oPM_Ready, expR);
      end
      testsRun++;
      if (bus0.oPM_LastStep !== expL) begin
        testsFailed++;
        $display("FAIL hold_laststep cycle %0d got %h want %h", k, bus0.oPM_LastStep, expL);
      end
      if (k == 12) drive(0, 8'h00, 3'b000, 16'd0);
    end
  endtask

  task automatic test_reset_mid_count();
    drive(0, 8'h01, 3'b000, 16'd100);
    @(posedge clk);
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (k == 0) drive(0, 8'h00, 3'b000, 16'd0);
      testsRun++;
      if (bus0.oPM_Ready !== 8'h00 || bus0.oPM_LastStep !== 8'h00) begin
        testsFailed++;
        $display("FAIL abort_run cycle %0d ready/laststep got %h/%h want 00/00",
                 k, bus0.oPM_Ready, bus0.oPM_LastStep);
      end
    end
    #2;
    rstN = 1'b0;
    #1;
    testsRun++;
    if (bus0.oPM_Ready !== 8'h01 || bus0.oPM_LastStep !== 8'h00) begin
      testsFailed++;
      $display("FAIL abort_reset ready/laststep got %h/%h want 01/00",
               bus0.oPM_Ready, bus0.oPM_LastStep);
    end
    @(negedge clk);
    rstN = 1'b1;
    run_cmd(0, 3'b000, 16'd2, "after_reset");
  endtask

  task automatic test_nonzero_bit();
    run_cmd(1, 3'b000, 16'd1, "bit3_n1");
    run_cmd(1, 3'b001, 16'd2, "bit3_presc");
  endtask

  task automatic test_back_to_back();
    int which;
    logic [2:0] opt;
    logic [15:0] n;
    for (int i = 0; i < 30; i++) begin
      which = $urandom_range(0, 1);
      opt   = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'($urandom);
      n     = 16'($urandom_range(0, 20));
      run_cmd(which, opt, n, "b2b_rand");
    end
  endtask

  initial begin
    test_reset();
    test_cycle_long();
    test_prescaled();
    test_filtering();
    test_reset_mid_count();
    test_nonzero_bit();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
